// File: rtl/token_table_scheduler.sv
// Boot loader and lookup/patch arbiter for the single-port token conversion table.
// Lookups win the port in RUN; a starvation guard forces a loader slot after STARVE_MAX denials.
module token_table_scheduler #(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 102,
    parameter int ADDR_W     = 7,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    input  logic              ld_valid,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              ld_ready,
    input  logic              lk_req,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_grant,
    output logic              lk_valid,
    output logic [WIDTH-1:0]  lk_data,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic              tbl_we,
    output logic [WIDTH-1:0]  tbl_wdata,
    input  logic [WIDTH-1:0]  tbl_rdata,
    output logic              table_ready,
    output logic              err_oob
);

    localparam int STW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);
    localparam logic [STW-1:0]    SMAX = STW'(STARVE_MAX);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [STW-1:0]    starve;
    logic              force_ld;
    logic              lk_oob;

    // Handshakes: a loader beat transfers on a cycle where ld_valid & ld_ready are both 1;
    // a lookup is taken on a cycle where lk_grant is 1 (lk_req is the valid), and its
    // result appears one cycle later as lk_valid/lk_data. Both are idle while reset is high.
    assign lk_grant  = ~reset & (state == RUN) & lk_req & ~force_ld;
    assign ld_ready  = ~reset & ~lk_grant;
    assign tbl_we    = ld_valid & ld_ready;
    assign tbl_wdata = ld_data;
    assign tbl_addr  = lk_grant ? lk_addr : wr_ptr;
    assign lk_oob    = (lk_addr > LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            wr_ptr      <= '0;
            starve      <= '0;
            force_ld    <= 1'b0;
            table_ready <= 1'b0;
            lk_valid    <= 1'b0;
            lk_data     <= '0;
            err_oob     <= 1'b0;
        end else begin
            if (tbl_we) begin
                wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                starve   <= '0;
                force_ld <= 1'b0;
                if (state == BOOT && wr_ptr == LAST) begin
                    state       <= RUN;
                    table_ready <= 1'b1;
                end
            end else if (state == RUN && ld_valid) begin
                // Force takes effect the cycle after the count reaches STARVE_MAX.
                if (starve != SMAX)
                    starve <= starve + 1'b1;
                if (starve >= SMAX - 1'b1)
                    force_ld <= 1'b1;
            end

            if (lk_grant) begin
                lk_valid <= 1'b1;
                lk_data  <= lk_oob ? '0 : tbl_rdata;
                if (lk_oob)
                    err_oob <= 1'b1;
            end else begin
                lk_valid <= 1'b0;
            end

            // reload overrides the pointer and sequencing but not the write or lookup itself.
            if (reload) begin
                state       <= BOOT;
                wr_ptr      <= '0;
                starve      <= '0;
                force_ld    <= 1'b0;
                table_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_token_table_scheduler.sv
// Bench for token_table_scheduler: directed scenarios plus random traffic, checked each
// cycle against a behavioural model of the boot/arbitration rules and a reference table.
module tb_token_table_scheduler;

    localparam int WIDTH      = 32;
    localparam int SIZE       = 102;
    localparam int ADDR_W     = 7;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              reload = 1'b0;
    logic              ld_valid = 1'b0;
    logic [WIDTH-1:0]  ld_data = '0;
    logic              ld_ready;
    logic              lk_req = 1'b0;
    logic [ADDR_W-1:0] lk_addr = '0;
    logic              lk_grant;
    logic              lk_valid;
    logic [WIDTH-1:0]  lk_data;
    logic [ADDR_W-1:0] tbl_addr;
    logic              tbl_we;
    logic [WIDTH-1:0]  tbl_wdata;
    logic [WIDTH-1:0]  tbl_rdata;
    logic              table_ready;
    logic              err_oob;

    int checks = 0;
    int errors = 0;

    token_table_scheduler #(
        .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset), .reload(reload),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .lk_req(lk_req), .lk_addr(lk_addr), .lk_grant(lk_grant),
        .lk_valid(lk_valid), .lk_data(lk_data),
        .tbl_addr(tbl_addr), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
        .table_ready(table_ready), .err_oob(err_oob)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // the physical table the DUT drives (covers the full address space)
    logic [WIDTH-1:0] tbl_mem [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) tbl_mem[i] = '0;
    always @(posedge clk) if (tbl_we) tbl_mem[tbl_addr] <= tbl_wdata;
    assign tbl_rdata = tbl_mem[tbl_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] ref_mem [0:SIZE-1];
    bit          m_boot, m_force, m_ready, m_valid, m_oob;
    int          m_ptr, m_wait;
    logic [31:0] m_data;
    initial for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;

    always @(negedge clk) begin
        bit e_grant, e_ldr, e_we;
        int e_addr;
        if (reset) begin
            chk("rst_lk_grant", 32'(lk_grant), 0);
            chk("rst_ld_ready", 32'(ld_ready), 0);
            chk("rst_tbl_we", 32'(tbl_we), 0);
            m_boot = 1; m_force = 0; m_ready = 0; m_valid = 0; m_oob = 0;
            m_ptr = 0; m_wait = 0; m_data = 0;
        end else begin
            chk("lk_valid", 32'(lk_valid), 32'(m_valid));
            chk("lk_data", lk_data, m_data);
            chk("table_ready", 32'(table_ready), 32'(m_ready));
            chk("err_oob", 32'(err_oob), 32'(m_oob));

            e_grant = !m_boot && lk_req && !m_force;
            e_ldr   = !e_grant;
            e_we    = ld_valid && e_ldr;
            e_addr  = e_grant ? int'(lk_addr) : m_ptr;
            chk("lk_grant", 32'(lk_grant), 32'(e_grant));
            chk("ld_ready", 32'(ld_ready), 32'(e_ldr));
            chk("tbl_we", 32'(tbl_we), 32'(e_we));
            chk("tbl_addr", 32'(tbl_addr), 32'(e_addr));
            if (e_we) chk("tbl_wdata", tbl_wdata, ld_data);

            if (e_grant) begin
                m_valid = 1;
                if (int'(lk_addr) >= SIZE) begin m_data = 0; m_oob = 1; end
                else m_data = ref_mem[int'(lk_addr)];
            end else m_valid = 0;

            if (e_we) begin
                ref_mem[m_ptr] = ld_data;
                if (m_boot && m_ptr == SIZE - 1) begin m_boot = 0; m_ready = 1; end
                m_ptr = (m_ptr + 1) % SIZE;
                m_wait = 0; m_force = 0;
            end else if (!m_boot && ld_valid) begin
                m_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
                if (m_wait == STARVE_MAX) m_force = 1;
            end

            if (reload) begin
                m_boot = 1; m_ready = 0; m_ptr = 0; m_wait = 0; m_force = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic boot_load(input int base, input int first);
        for (int i = first; i < SIZE; i++) begin
            if (i == 17 || i == 55 || i == 90) begin
                ld_valid = 0; tick();
            end
            ld_valid = 1; ld_data = 32'(base + i); tick();
        end
        ld_valid = 0;
    endtask

    initial begin
        int found;
        // reset with loader already presenting data
        reset = 1; ld_valid = 1; ld_data = 32'h55;
        tick(); tick();
        chk("rst_lk_valid", 32'(lk_valid), 0);
        chk("rst_table_ready", 32'(table_ready), 0);
        reset = 0; ld_valid = 0;
        #1 chk("post_rst_ld_ready", 32'(ld_ready), 1);

        // full boot with gaps
        boot_load(32'h100, 0);
        chk("boot_table_ready", 32'(table_ready), 1);
        #1 chk("boot_wr_ptr_wrapped", 32'(tbl_addr), 0);
        lk_req = 1; lk_addr = 5; tick();
        chk("lookup5_valid", 32'(lk_valid), 1);
        chk("lookup5_data", lk_data, 32'h105);

        // back-to-back lookups
        lk_addr = 0;   tick(); chk("b2b0", lk_data, 32'h100); chk("b2b0_v", 32'(lk_valid), 1);
        lk_addr = 1;   tick(); chk("b2b1", lk_data, 32'h101); chk("b2b1_v", 32'(lk_valid), 1);
        lk_addr = 2;   tick(); chk("b2b2", lk_data, 32'h102); chk("b2b2_v", 32'(lk_valid), 1);
        lk_addr = 101; tick(); chk("b2b3", lk_data, 32'h165); chk("b2b3_v", 32'(lk_valid), 1);

        // starvation: the loader must win on its 9th waiting cycle
        lk_addr = 3; ld_valid = 1; ld_data = 32'hDEAD; found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            #1;
            if (tbl_we) begin
                found = c;
                chk("starve_grant_low", 32'(lk_grant), 0);
                chk("starve_addr", 32'(tbl_addr), 0);
            end
            tick();
        end
        chk("starve_cycle", 32'(found), 9);
        #1 chk("starve_resume", 32'(lk_grant), 1);
        ld_valid = 0; lk_addr = 0; tick(); tick();
        chk("starve_readback", lk_data, 32'hDEAD);

        // out-of-range lookup
        lk_addr = 110; tick();
        chk("oob_valid", 32'(lk_valid), 1);
        chk("oob_data", lk_data, 0);
        chk("oob_err", 32'(err_oob), 1);
        lk_req = 0;
        repeat (10) tick();
        chk("oob_sticky", 32'(err_oob), 1);

        // reload with granted lookup and pending write
        lk_req = 1; lk_addr = 2; ld_valid = 1; ld_data = 32'hBEEF; reload = 1;
        tick();
        reload = 0;
        chk("reload_lk_valid", 32'(lk_valid), 1);
        chk("reload_lk_data", lk_data, 32'h102);
        chk("reload_table_ready", 32'(table_ready), 0);
        ld_data = 32'h200;
        #1;
        chk("reload_first_we", 32'(tbl_we), 1);
        chk("reload_first_addr", 32'(tbl_addr), 0);
        chk("reload_grant_low", 32'(lk_grant), 0);
        tick();
        boot_load(32'h200, 1);
        chk("reboot_table_ready", 32'(table_ready), 1);
        lk_addr = 7; tick();
        chk("reboot_lookup7", lk_data, 32'h207);
        lk_req = 0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            lk_req   = ($urandom_range(0, 3) != 0);
            lk_addr  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 127))
                                                   : ADDR_W'($urandom_range(0, SIZE - 1));
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_data  = $urandom;
            reload   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reload = 0; lk_req = 0; ld_valid = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
